// File: rtl/mux_seq_pkg.sv
// Shared types and round-robin helper for the mux select sequencer.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
//
// Contents: NUM_CH / SEL_W sizing, state_t (IDLE, HOLD), next_ch() pick.
package mux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Search req starting one past the last granted channel, ascending with
  // wrap; the first set bit wins. With no bit set the result is a don't-care
  // (callers only use it when |req), so it falls back to last+1.
  function automatic logic [SEL_W-1:0] next_ch(input logic [NUM_CH-1:0] req,
                                               input logic [SEL_W-1:0]  last);
    logic [SEL_W-1:0] cand;
    logic             found;
    next_ch = last + SEL_W'(1);
    found   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      // i == NUM_CH truncates to 0, i.e. the last channel itself is tried last
      cand = last + SEL_W'(i);
      if (!found && req[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin channel picker over a 4-bit request mask.
// Latency: combinational, zero cycles.
// Backpressure: none; result is only meaningful when |req.
//
// Ports: req  - request mask, bit n = channel n
//        last - most recently granted channel
//        pick - next channel to grant
module rr_pick
  import mux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  pick
);

  always_comb begin
    pick = next_ch(req, last);
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Select generator for mux4_to_1: round-robin over requested channels, each held DWELL cycles.
// Latency: grant visible one cycle after enable && |req is sampled; no gap between dwells.
// Backpressure: none; req/enable only sampled in IDLE or at the end of a dwell, a dwell is never cut short.
//
// Ports: clock, reset (sync, active-high), enable, req[3:0] in;
//        s1/s0 select, sel_valid, strobe (last dwell cycle) out.
// Optional macro SEQ_CAPTURE_EN adds mux_out in, sample_data[3:0] and
// sample_valid out: mux_out is latched per channel on each strobe.
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] req,
  output logic              s1,
  output logic              s0,
  output logic              sel_valid,
  output logic              strobe
`ifdef SEQ_CAPTURE_EN
  ,
  input  logic              mux_out,
  output logic [NUM_CH-1:0] sample_data,
  output logic              sample_valid
`endif
);

  // Counter runs DWELL-1 down to 0, so DWELL == 2**CNT_W still fits.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] pick;
  logic [CNT_W-1:0] count;
  logic             go;

  assign go = enable && (|req);
  assign s1 = sel[1];
  assign s0 = sel[0];

  rr_pick u_rr_pick (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      last      <= SEL_W'(NUM_CH - 1);  // first pick then starts at channel 0
      count     <= '0;
      sel_valid <= 1'b0;
      strobe    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state     <= HOLD;
            sel       <= pick;
            last      <= pick;
            count     <= RELOAD;
            sel_valid <= 1'b1;
            strobe    <= (RELOAD == '0);
          end
        end
        HOLD: begin
          if (count == '0) begin
            if (go) begin
              // back-to-back grant, possibly the same channel again
              sel       <= pick;
              last      <= pick;
              count     <= RELOAD;
              sel_valid <= 1'b1;
              strobe    <= (RELOAD == '0);
            end else begin
              state     <= IDLE;
              sel_valid <= 1'b0;
              strobe    <= 1'b0;
            end
          end else begin
            count  <= count - CNT_W'(1);
            // registered strobe lines up with the cycle where count reads 0
            strobe <= (count == CNT_W'(1));
          end
        end
        default: begin
          state     <= IDLE;
          sel_valid <= 1'b0;
          strobe    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_CAPTURE_EN
  // strobe and sel are both registered, so on a strobe edge sel still names
  // the channel whose dwell is ending.
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= strobe;
      if (strobe) begin
        sample_data[sel] <= mux_out;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_select_sequencer.sv
module tb_mux_select_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] req;

  // DWELL=4 instance
  logic       s1, s0, sel_valid, strobe;
  // DWELL=1 instance, same inputs
  logic       s1_d1, s0_d1, sel_valid_d1, strobe_d1;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_CAPTURE_EN
  logic [3:0] ivec = 4'b0101;  // i0=1, i1=0, i2=1, i3=0
  logic       mux_out;
  logic [3:0] sample_data, sample_data_d1;
  logic       sample_valid, sample_valid_d1;
  assign mux_out = ivec[{s1, s0}];
`endif

  mux_select_sequencer #(.DWELL(4), .CNT_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .s1        (s1),
    .s0        (s0),
    .sel_valid (sel_valid),
    .strobe    (strobe)
`ifdef SEQ_CAPTURE_EN
    ,
    .mux_out      (mux_out),
    .sample_data  (sample_data),
    .sample_valid (sample_valid)
`endif
  );

  mux_select_sequencer #(.DWELL(1), .CNT_W(8)) dut_d1 (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .s1        (s1_d1),
    .s0        (s0_d1),
    .sel_valid (sel_valid_d1),
    .strobe    (strobe_d1)
`ifdef SEQ_CAPTURE_EN
    ,
    .mux_out      (1'b0),
    .sample_data  (sample_data_d1),
    .sample_valid (sample_valid_d1)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {s1,s0,sel_valid,strobe}
  function automatic logic [3:0] pk(input int ch, input bit v, input bit st);
    logic [1:0] c;
    c = 2'(ch);
    return {c, v, st};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    req    = 4'b0000;
    step();
    step();
    reset  = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    req    = 4'b0000;

    // 1: reset held 3 cycles, then released with enable low
    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_hold", {s1, s0, sel_valid, strobe}, pk(0, 0, 0));
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_after_reset", {s1, s0, sel_valid, strobe}, pk(0, 0, 0));
    end

    // 2: all four channels, 4 cycles each, strobe on 4th; DWELL=1 advances every cycle
    do_reset();
    req    = 4'b1111;
    enable = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      check("rr_all", {s1, s0, sel_valid, strobe}, pk((k / 4) % 4, 1, (k % 4) == 3));
      check("dwell1", {s1_d1, s0_d1, sel_valid_d1, strobe_d1}, pk(k % 4, 1, 1));
    end

    // 3: only channels 0 and 2 requested
    do_reset();
    req    = 4'b0101;
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      check("rr_0101", {s1, s0, sel_valid, strobe}, pk(((k / 4) % 2) * 2, 1, (k % 4) == 3));
    end

    // 4: req switches mid-dwell; channel 0 finishes, then channel 3 re-granted each dwell
    do_reset();
    req    = 4'b0001;
    enable = 1'b1;
    step(); check("req_chg_c1", {s1, s0, sel_valid, strobe}, pk(0, 1, 0));
    step(); check("req_chg_c2", {s1, s0, sel_valid, strobe}, pk(0, 1, 0));
    req = 4'b1000;
    step(); check("req_chg_c3", {s1, s0, sel_valid, strobe}, pk(0, 1, 0));
    step(); check("req_chg_c4", {s1, s0, sel_valid, strobe}, pk(0, 1, 1));
    step(); check("ch3_c1",     {s1, s0, sel_valid, strobe}, pk(3, 1, 0));
    step(); check("ch3_c2",     {s1, s0, sel_valid, strobe}, pk(3, 1, 0));
    step(); check("ch3_c3",     {s1, s0, sel_valid, strobe}, pk(3, 1, 0));
    step(); check("ch3_c4",     {s1, s0, sel_valid, strobe}, pk(3, 1, 1));
    step(); check("ch3_regrant",{s1, s0, sel_valid, strobe}, pk(3, 1, 0));

    // 5: enable dropped mid-dwell, then reset mid-HOLD
    do_reset();
    req    = 4'b1111;
    enable = 1'b1;
    step(); check("en_drop_c1", {s1, s0, sel_valid, strobe}, pk(0, 1, 0));
    step(); check("en_drop_c2", {s1, s0, sel_valid, strobe}, pk(0, 1, 0));
    enable = 1'b0;
    step(); check("en_drop_c3", {s1, s0, sel_valid, strobe}, pk(0, 1, 0));
    step(); check("en_drop_c4", {s1, s0, sel_valid, strobe}, pk(0, 1, 1));
    step(); check("en_drop_idle1", {s1, s0, sel_valid, strobe}, pk(0, 0, 0));
    step(); check("en_drop_idle2", {s1, s0, sel_valid, strobe}, pk(0, 0, 0));
    enable = 1'b1;
    step(); check("resume_ch1_c1", {s1, s0, sel_valid, strobe}, pk(1, 1, 0));
    step(); check("resume_ch1_c2", {s1, s0, sel_valid, strobe}, pk(1, 1, 0));
    step(); check("resume_ch1_c3", {s1, s0, sel_valid, strobe}, pk(1, 1, 0));
    reset = 1'b1;
    step(); check("reset_mid_hold", {s1, s0, sel_valid, strobe}, pk(0, 0, 0));
    reset = 1'b0;
    step(); check("after_reset_ch0", {s1, s0, sel_valid, strobe}, pk(0, 1, 0));

`ifdef SEQ_CAPTURE_EN
    // 6: capture of mux output per channel on each strobe
    do_reset();
    check("cap_reset_data",  {28'd0, sample_data}, 32'h0);
    check("cap_reset_valid", {31'd0, sample_valid}, 32'h0);
    req    = 4'b1111;
    enable = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      check("cap_valid", {31'd0, sample_valid}, {31'd0, (k % 4 == 0) && (k > 0)});
      if (k == 4)  check("cap_data_ch0", {28'd0, sample_data}, 32'h1);
      if (k == 12) check("cap_data_ch2", {28'd0, sample_data}, 32'h5);
    end
    check("cap_data_round", {28'd0, sample_data}, 32'h5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
